// File: rtl/blk_mem_gen_1_pkg.sv
// rtl/blk_mem_gen_1_pkg.sv - default geometry and word/address types for blk_mem_gen_1
package blk_mem_gen_1_pkg;

    localparam int DFLT_ADDR_W = 4;
    localparam int DFLT_DATA_W = 16;
    localparam int DFLT_DEPTH  = 1 << DFLT_ADDR_W;

    typedef logic [DFLT_ADDR_W-1:0] addr_t;
    typedef logic [DFLT_DATA_W-1:0] data_t;

endpackage

// File: rtl/blk_mem_gen_1_array.sv
// rtl/blk_mem_gen_1_array.sv - resettable register array, one write port, one registered read port
module blk_mem_gen_1_array
    import blk_mem_gen_1_pkg::*;
#(
    parameter int ADDR_W = DFLT_ADDR_W,
    parameter int DATA_W = DFLT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Samples the pre-write contents, so a same-address write reads first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/blk_mem_gen_1.sv
// rtl/blk_mem_gen_1.sv - simple dual-port RAM top; BLK_MEM_GEN_1_OUT_REG_EN adds an output register
module blk_mem_gen_1
    import blk_mem_gen_1_pkg::*;
#(
    parameter int ADDR_W = DFLT_ADDR_W,
    parameter int DATA_W = DFLT_DATA_W
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              clkb,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    logic [DATA_W-1:0] rd_data;

    // clkb shares the clka net; everything is clocked by clka
    logic unused_clkb;
    assign unused_clkb = clkb;

    blk_mem_gen_1_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (clka),
        .rst  (rst),
        .we   (wea),
        .waddr(addra),
        .wdata(dina),
        .raddr(addrb),
        .rdata(rd_data)
    );

`ifdef BLK_MEM_GEN_1_OUT_REG_EN
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            doutb <= '0;
        end else begin
            doutb <= rd_data;
        end
    end
`else
    assign doutb = rd_data;
`endif

endmodule

// File: tb/tb_blk_mem_gen_1.sv
// tb/tb_blk_mem_gen_1.sv - scoreboard bench for blk_mem_gen_1
module tb_blk_mem_gen_1;
    import blk_mem_gen_1_pkg::*;

`ifdef BLK_MEM_GEN_1_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        bit    chk;
        data_t val;
        int    id;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    addr_t addra = '0;
    data_t dina = '0;
    logic  wea = 1'b0;
    addr_t addrb = '0;
    data_t doutb;

    exp_t  exp_q[$];
    data_t model [DFLT_DEPTH];
    int    n_chk = 0;
    int    n_fail = 0;
    int    vec_id = 0;

    blk_mem_gen_1 dut (
        .clka (clk),
        .rst  (rst),
        .clkb (clk),
        .addra(addra),
        .dina (dina),
        .wea  (wea),
        .addrb(addrb),
        .doutb(doutb)
    );

    always #5 clk = ~clk;

    // Monitor: doutb after edge N belongs to the entry issued LAT-1 edges earlier
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                n_chk++;
                if (doutb !== e.val) begin
                    n_fail++;
                    $display("FAIL rd#%0d: doutb=%h expected=%h", e.id, doutb, e.val);
                end
            end
        end
    end

    // Called at a negedge; drives one edge of stimulus and returns at the next negedge
    task automatic step(input logic we, input int aa, input data_t da, input int ab,
                        input bit chk, input bit use_hand, input data_t hand);
        exp_t e;
        addra = addr_t'(aa);
        dina  = da;
        wea   = we;
        addrb = addr_t'(ab);
        e.chk = chk;
        e.val = use_hand ? hand : model[ab];
        e.id  = vec_id++;
        exp_q.push_back(e);
        if (we) model[aa] = da;
        @(negedge clk);
    endtask

    task automatic wr(input int aa, input data_t da, input int ab, input data_t hand);
        step(1'b1, aa, da, ab, 1'b1, 1'b1, hand);
    endtask

    task automatic rd(input int ab, input data_t hand);
        step(1'b0, 0, '0, ab, 1'b1, 1'b1, hand);
    endtask

    task automatic idle();
        step(1'b0, 0, '0, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DFLT_DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (doutb !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dout: doutb=%h expected=0000", doutb);
        end
        rst = 1'b0;

        for (int a = 0; a < 16; a++) rd(a, 16'h0000);

        wr(3, 16'hA5A5, 0, 16'h0000);
        rd(3, 16'hA5A5);

        wr(7, 16'h1111, 0, 16'h0000);
        wr(7, 16'h2222, 7, 16'h1111);
        rd(7, 16'h2222);

        step(1'b0, 5, 16'hFFFF, 5, 1'b1, 1'b1, 16'h0000);
        rd(5, 16'h0000);

        wr(9, 16'h1234, 3, 16'hA5A5);
        rd(9, 16'h1234);

        wr(15, 16'hBEEF, 0, 16'h0000);
        wr(0, 16'h0F0F, 15, 16'hBEEF);
        rd(0, 16'h0F0F);

        for (int i = 0; i < 1000; i++) begin
            step(1'b1, int'($urandom_range(0, 15)), data_t'($urandom), i % 16,
                 1'b1, 1'b0, '0);
        end
        idle();
        idle();

        // Make sure doutb holds something nonzero so the async clear is visible
        wr(4, 16'hC3C3, 4, model[4]);
        rd(4, 16'hC3C3);
        idle();

        rst   = 1'b1;
        wea   = 1'b1;
        addra = 4'd2;
        dina  = 16'h5555;
        exp_q.delete();
        #1;
        n_chk++;
        if (doutb !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_rst_dout: doutb=%h expected=0000", doutb);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();

        for (int a = 0; a < 16; a++) rd(a, 16'h0000);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/blk_mem_gen_1.md
BLK_MEM_GEN_1 -- requirements
Module: blk_mem_gen_1

Interface
REQ-001 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W = 16 words.
REQ-002 Parameter DATA_W, default 16, word width in bits.
REQ-003 clka  input  1  sole clock; all sequential logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clkb  input  1  port-B clock pin, kept for compatibility; SHALL be driven from the same net as clka; all logic is clocked by clka only.
REQ-006 addra  input  ADDR_W  port-A write address.
REQ-007 dina  input  DATA_W  port-A write data.
REQ-008 wea  input  1  port-A write enable, active-high.
REQ-009 addrb  input  ADDR_W  port-B read address.
REQ-010 doutb  output  DATA_W  port-B read data, registered.

Function
REQ-011 Write: at a rising clka edge with wea=1 and rst=0, mem[addra] SHALL take dina; with wea=0 memory is unchanged.
REQ-012 Read: doutb SHALL equal mem[addrb] as sampled at edge N, valid after edge N (latency 1) with the macro off.
REQ-013 Port B reads every cycle; there is no read enable, and doutb updates on every edge.
REQ-014 Collision (wea=1, addra==addrb at the same edge): read-first; doutb SHALL show the old contents, and the new data is visible on the next read.
REQ-015 Addresses are full-range: all 16 locations are valid; no wrap or out-of-range case exists.
REQ-016 Unknown (X) addresses or data are not checked; the design adds no sanitising logic.
REQ-017 Both ports are independent: a write and a read to different addresses in one cycle both complete.

Reset
REQ-018 While rst=1: all 16 memory words and doutb SHALL be 0 immediately, without waiting for a clock edge.
REQ-019 Writes presented while rst=1 are discarded.
REQ-020 Reset asserted mid-operation aborts any in-flight read; the first valid read returns at latency 1 (or 2) after the first edge with rst=0.

Configuration
REQ-021 Macro BLK_MEM_GEN_1_OUT_REG_EN:
- Defined: an extra output register follows the read register, giving read latency 2; the collision rule (REQ-014) applies at the first stage; the extra register is reset to 0.
- Undefined: read latency is 1, as in REQ-012.

Structure
REQ-022 Package blk_mem_gen_1_pkg SHALL hold the default ADDR_W, DATA_W, DEPTH constants and an addr_t and data_t typedef.
REQ-023 One sub-module, blk_mem_gen_1_array: a resettable register array with a write port and a registered read port; the top module adds the optional output stage.

Verification
REQ-024 Reset: assert rst for 3 edges, then read addrb=0..15 -> doutb=0x0000 at every address.
REQ-025 Write then read: write 0xA5A5 to addr 3; next cycle addrb=3 -> doutb=0xA5A5 after 1 edge (2 with the macro).
REQ-026 Collision: mem[7]=0x1111; at the same edge write 0x2222 to 7 with addrb=7 -> doutb=0x1111; one edge later -> 0x2222.
REQ-027 wea=0: drive addra=5, dina=0xFFFF, wea=0 -> mem[5] is unchanged (reads 0x0000 after reset).
REQ-028 Random streaming: each cycle a random addra/dina with wea=1, and addrb incrementing 0..15 then wrapping -> doutb matches a scoreboard model for 1000 cycles.
REQ-029 Async reset mid-stream: raise rst between edges -> doutb=0 before the next edge, and all locations read 0 afterwards.
